// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side bundle for alu_arbiter.
// The arbiter uses the slave view; the issuing units and the ALU use the master view.
interface alu_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = 4
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_op1;
    logic [DATA_WIDTH-1:0] req0_op2;
    logic [SEL_WIDTH-1:0]  req0_sel;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_op1;
    logic [DATA_WIDTH-1:0] req1_op2;
    logic [SEL_WIDTH-1:0]  req1_sel;

    logic                  rsp0_valid;
    logic                  rsp0_ready;
    logic [DATA_WIDTH-1:0] rsp0_data;
    logic                  rsp0_err;
    logic                  rsp1_valid;
    logic                  rsp1_ready;
    logic [DATA_WIDTH-1:0] rsp1_data;
    logic                  rsp1_err;

    logic [DATA_WIDTH-1:0] alu_op1;
    logic [DATA_WIDTH-1:0] alu_op2;
    logic [SEL_WIDTH-1:0]  alu_sel;
    logic [DATA_WIDTH-1:0] alu_out;
    logic                  busy;

    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_sel,
        input  req1_valid, req1_op1, req1_op2, req1_sel,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp0_err,
        output rsp1_valid, rsp1_data, rsp1_err,
        input  rsp0_ready, rsp1_ready,
        output alu_op1, alu_op2, alu_sel, busy,
        input  alu_out
    );

    modport master (
        output req0_valid, req0_op1, req0_op2, req0_sel,
        output req1_valid, req1_op1, req1_op2, req1_sel,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp0_err,
        input  rsp1_valid, rsp1_data, rsp1_err,
        output rsp0_ready, rsp1_ready,
        input  alu_op1, alu_op2, alu_sel, busy,
        output alu_out
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter sharing one external combinational ALU.
// Operands are registered on grant; the ALU result is captured one cycle later.
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;
    localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(10);

    logic [0:0]            r_state;
    logic                  r_last;
    logic                  r_owner;
    logic                  r_illegal;
    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] r_op2;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic [1:0]            r_rsp_valid;
    logic [1:0]            r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp0_data;
    logic [DATA_WIDTH-1:0] r_rsp1_data;

    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic [DATA_WIDTH-1:0] w_op1;
    logic [DATA_WIDTH-1:0] w_op2;
    logic [SEL_WIDTH-1:0]  w_sel;
    logic                  w_illegal;
    logic [DATA_WIDTH-1:0] w_result;

    // A port with an undrained result is not eligible, even if it drains this cycle.
    always_comb begin
        w_elig0   = (r_state == IDLE) && bus.req0_valid && !r_rsp_valid[0];
        w_elig1   = (r_state == IDLE) && bus.req1_valid && !r_rsp_valid[1];
        w_gnt0    = w_elig0 && (!w_elig1 || r_last);
        w_gnt1    = w_elig1 && (!w_elig0 || !r_last);
        w_op1     = w_gnt1 ? bus.req1_op1 : bus.req0_op1;
        w_op2     = w_gnt1 ? bus.req1_op2 : bus.req0_op2;
        w_sel     = w_gnt1 ? bus.req1_sel : bus.req0_sel;
        w_illegal = (w_sel > SEL_LAST);
        w_result  = r_illegal ? '0 : bus.alu_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_illegal   <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_sel       <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= '0;
            r_rsp0_data <= '0;
            r_rsp1_data <= '0;
        end else begin
            if (r_rsp_valid[0] && bus.rsp0_ready) r_rsp_valid[0] <= 1'b0;
            if (r_rsp_valid[1] && bus.rsp1_ready) r_rsp_valid[1] <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_state   <= EXEC;
                        r_owner   <= w_gnt1;
                        r_last    <= w_gnt1;
                        r_op1     <= w_op1;
                        r_op2     <= w_op2;
                        r_sel     <= w_illegal ? '0 : w_sel;
                        r_illegal <= w_illegal;
                    end
                end
                EXEC: begin
                    r_state                <= IDLE;
                    r_rsp_valid[r_owner]   <= 1'b1;
                    r_rsp_err[r_owner]     <= r_illegal;
                    if (r_owner) r_rsp1_data <= w_result;
                    else         r_rsp0_data <= w_result;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = w_gnt0 && rst;
    assign bus.req1_ready = w_gnt1 && rst;
    assign bus.rsp0_valid = r_rsp_valid[0];
    assign bus.rsp1_valid = r_rsp_valid[1];
    assign bus.rsp0_err   = r_rsp_err[0];
    assign bus.rsp1_err   = r_rsp_err[1];
    assign bus.rsp0_data  = r_rsp0_data;
    assign bus.rsp1_data  = r_rsp1_data;
    assign bus.alu_op1    = r_op1;
    assign bus.alu_op2    = r_op2;
    assign bus.alu_sel    = r_sel;
    assign bus.busy       = (r_state == EXEC);
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: external ALU model, per-cycle transaction-level reference
// checked on every falling edge, plus directed scenarios with literal expectations.
module tb_alu_arbiter;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    alu_arbiter_if #(.DATA_WIDTH(32), .SEL_WIDTH(4)) bus ();

    alu_arbiter #(.DATA_WIDTH(32), .SEL_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return 32'($signed(a) >>> b[4:0]);
            4'd10:   return a;
            default: return 32'd0;
        endcase
    endfunction

    always_comb bus.alu_out = alu_ref(bus.alu_sel, bus.alu_op1, bus.alu_op2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference state: one in-flight operation, two result slots, last-granted port.
    bit          m_inflight;
    bit          m_fl_port;
    logic [31:0] m_fl_data;
    bit          m_fl_err;
    bit          m_last;
    bit          m_full [2];
    logic [31:0] m_data [2];
    bit          m_err  [2];
    logic [31:0] m_aop1, m_aop2;
    logic [3:0]  m_asel;

    always @(negedge clk) begin
        bit          el0, el1, rdy0, rdy1;
        logic [31:0] a, b;
        logic [3:0]  s;
        if (!rst) begin
            chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
            chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
            chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
            chk("rst_rsp0_data", bus.rsp0_data, 32'd0);
            chk("rst_rsp1_data", bus.rsp1_data, 32'd0);
            chk("rst_rsp0_err", 32'(bus.rsp0_err), 32'd0);
            chk("rst_rsp1_err", 32'(bus.rsp1_err), 32'd0);
            chk("rst_alu_op1", bus.alu_op1, 32'd0);
            chk("rst_alu_op2", bus.alu_op2, 32'd0);
            chk("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
            m_inflight = 0; m_last = 1;
            m_aop1 = '0; m_aop2 = '0; m_asel = '0;
            for (int i = 0; i < 2; i++) begin
                m_full[i] = 0; m_data[i] = '0; m_err[i] = 0;
            end
        end else begin
            el0  = !m_inflight && bus.req0_valid && !m_full[0];
            el1  = !m_inflight && bus.req1_valid && !m_full[1];
            rdy0 = el0 && (!el1 || m_last == 1'b1);
            rdy1 = el1 && (!el0 || m_last == 1'b0);
            chk("ready0", 32'(bus.req0_ready), 32'(rdy0));
            chk("ready1", 32'(bus.req1_ready), 32'(rdy1));
            chk("busy", 32'(bus.busy), 32'(m_inflight));
            chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(m_full[0]));
            chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(m_full[1]));
            if (m_full[0]) begin
                chk("rsp0_data", bus.rsp0_data, m_data[0]);
                chk("rsp0_err", 32'(bus.rsp0_err), 32'(m_err[0]));
            end
            if (m_full[1]) begin
                chk("rsp1_data", bus.rsp1_data, m_data[1]);
                chk("rsp1_err", 32'(bus.rsp1_err), 32'(m_err[1]));
            end
            chk("alu_op1", bus.alu_op1, m_aop1);
            chk("alu_op2", bus.alu_op2, m_aop2);
            chk("alu_sel", 32'(bus.alu_sel), 32'(m_asel));
            // advance to the state after the coming rising edge
            if (m_full[0] && bus.rsp0_ready) m_full[0] = 0;
            if (m_full[1] && bus.rsp1_ready) m_full[1] = 0;
            if (m_inflight) begin
                m_inflight          = 0;
                m_full[m_fl_port]   = 1;
                m_data[m_fl_port]   = m_fl_data;
                m_err[m_fl_port]    = m_fl_err;
            end else if (rdy0 || rdy1) begin
                a = rdy1 ? bus.req1_op1 : bus.req0_op1;
                b = rdy1 ? bus.req1_op2 : bus.req0_op2;
                s = rdy1 ? bus.req1_sel : bus.req0_sel;
                m_inflight = 1;
                m_fl_port  = rdy1;
                m_last     = rdy1;
                m_fl_err   = (s > 4'd10);
                m_fl_data  = m_fl_err ? 32'd0 : alu_ref(s, a, b);
                m_aop1 = a; m_aop2 = b; m_asel = m_fl_err ? 4'd0 : s;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] sel);
        if (port == 0) begin
            bus.req0_op1 = a; bus.req0_op2 = b; bus.req0_sel = sel; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_op1 = a; bus.req1_op2 = b; bus.req1_sel = sel; bus.req1_valid = 1'b1;
        end
    endtask

    task automatic wait_ready(input int port, input string name);
        bit got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = (port == 0) ? bus.req0_ready : bus.req1_ready;
            tick();
        end
        chk({name, "_accept"}, 32'(got), 32'd1);
        if (port == 0) bus.req0_valid = 1'b0;
        else           bus.req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int port, input logic [31:0] exp_d, input bit exp_e,
                            input string name);
        bit got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = (port == 0) ? bus.rsp0_valid : bus.rsp1_valid;
            if (got) begin
                chk({name, "_data"}, (port == 0) ? bus.rsp0_data : bus.rsp1_data, exp_d);
                chk({name, "_err"}, 32'((port == 0) ? bus.rsp0_err : bus.rsp1_err), 32'(exp_e));
            end
            tick();
        end
        chk({name, "_rsp"}, 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [31:0] exp;
        bit          err;
    } vec_t;

    initial begin
        vec_t vecs [9];
        int   grants [$];
        int   nacc;
        bit   served0;

        rst = 1'b0;
        bus.req0_op1 = '0; bus.req0_op2 = '0; bus.req0_sel = '0;
        bus.req1_op1 = '0; bus.req1_op2 = '0; bus.req1_sel = '0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        @(negedge clk);
        chk("reset_ready_gated", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        tick();
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        rst = 1'b1;
        tick();

        // single ADD on port 0, exact latency
        set_req(0, 32'd5, 32'd7, 4'd0);
        @(negedge clk);
        chk("add_ready", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("add_busy", 32'(bus.busy), 32'd1);
        tick();
        @(negedge clk);
        chk("add_rsp_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("add_data", bus.rsp0_data, 32'd12);
        chk("add_err", 32'(bus.rsp0_err), 32'd0);
        chk("add_rsp1_quiet", 32'(bus.rsp1_valid), 32'd0);
        tick();

        // contention from reset: grants must alternate starting at port 0
        do_reset();
        set_req(0, 32'd10, 32'd3, 4'd1);
        set_req(1, 32'd1, 32'd4, 4'd7);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.req0_ready) grants.push_back(0);
            if (bus.req1_ready) grants.push_back(1);
            if (bus.rsp0_valid) chk("cont_rsp0", bus.rsp0_data, 32'd7);
            if (bus.rsp1_valid) chk("cont_rsp1", bus.rsp1_data, 32'd16);
            tick();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chk("cont_accepts", 32'(grants.size()), 32'd4);
        if (grants.size() == 4)
            chk("cont_order", 32'({grants[0][0], grants[1][0], grants[2][0], grants[3][0]}),
                32'b0101);
        repeat (3) tick();

        // one port, rsp_ready high: one accept every 3 cycles
        nacc = 0;
        set_req(0, 32'd1, 32'd2, 4'd0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (bus.req0_ready) nacc++;
            tick();
        end
        bus.req0_valid = 1'b0;
        chk("single_port_rate", 32'(nacc), 32'd3);
        repeat (3) tick();

        // backpressure on port 1 while port 0 is served
        bus.rsp1_ready = 1'b0;
        set_req(1, 32'd1, 32'hFFFF_FFFF, 4'd6);
        wait_ready(1, "bp_first");
        set_req(1, 32'd2, 32'd3, 4'd0);
        set_req(0, 32'd100, 32'd1, 4'd0);
        served0 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("bp_hold_valid", 32'(bus.rsp1_valid), 32'd1);
                chk("bp_hold_data", bus.rsp1_data, 32'd1);
                chk("bp_blocked", 32'(bus.req1_ready), 32'd0);
            end
            if (bus.req0_ready) served0 = 1;
            tick();
            if (served0) bus.req0_valid = 1'b0;
        end
        chk("bp_port0_served", 32'(served0), 32'd1);
        bus.rsp1_ready = 1'b1;
        wait_ready(1, "bp_second");
        wait_rsp(1, 32'd5, 1'b0, "bp_second");
        tick();

        // illegal select on port 0
        set_req(0, 32'h1234, 32'h55, 4'd13);
        @(negedge clk);
        chk("ill_ready", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("ill_alu_sel", 32'(bus.alu_sel), 32'd0);
        chk("ill_alu_op1", bus.alu_op1, 32'h1234);
        tick();
        @(negedge clk);
        chk("ill_rsp_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("ill_rsp_err", 32'(bus.rsp0_err), 32'd1);
        chk("ill_rsp_data", bus.rsp0_data, 32'd0);
        tick();
        set_req(0, 32'hF0, 32'hFF, 4'd4);
        wait_ready(0, "ill_next");
        wait_rsp(0, 32'h0F, 1'b0, "ill_next");

        // reset during EXEC discards the operation
        set_req(0, 32'd1, 32'd1, 4'd0);
        wait_ready(0, "rx");
        rst = 1'b0;
        @(negedge clk);
        chk("rx_busy", 32'(bus.busy), 32'd0);
        chk("rx_alu_op1", bus.alu_op1, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rx_no_rsp", 32'(bus.rsp0_valid), 32'd0);
            tick();
        end
        set_req(0, 32'd3, 32'd4, 4'd0);
        set_req(1, 32'd5, 32'd6, 4'd0);
        @(negedge clk);
        chk("rx_first_grant", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_rsp(0, 32'd7, 1'b0, "rx_after");

        // operation table
        vecs[0] = '{1, 32'h8000_0000, 32'd4,  4'd9,  32'hF800_0000, 1'b0};
        vecs[1] = '{0, 32'hFFFF_FFFF, 32'd1,  4'd5,  32'd1,         1'b0};
        vecs[2] = '{1, 32'hF0F0,      32'hFF00, 4'd2, 32'hF000,     1'b0};
        vecs[3] = '{0, 32'h0F,        32'hF0, 4'd3,  32'hFF,        1'b0};
        vecs[4] = '{1, 32'h8000_0000, 32'd4,  4'd8,  32'h0800_0000, 1'b0};
        vecs[5] = '{0, 32'hDEAD_BEEF, 32'd5,  4'd10, 32'hDEAD_BEEF, 1'b0};
        vecs[6] = '{1, 32'd0,         32'd1,  4'd1,  32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{0, 32'hFFFF_FFFF, 32'd2,  4'd0,  32'd1,         1'b0};
        vecs[8] = '{1, 32'd9,         32'd9,  4'd15, 32'd0,         1'b1};
        foreach (vecs[i]) begin
            set_req(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].sel);
            wait_ready(vecs[i].port, $sformatf("vec%0d", i));
            wait_rsp(vecs[i].port, vecs[i].exp, vecs[i].err, $sformatf("vec%0d", i));
        end
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
